// File: rtl/sprite_renderer.sv
// Drives a rotating 1-bit sprite shift register from beam position: issues
// shiftf/shiftb strobes, registers the serial bit as pixel_on, realigns per frame.
module sprite_renderer #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 10,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [1:0]         scale,
  input  logic               sprite_bit,
  output logic               shiftf,
  output logic               shiftb,
  output logic               pixel_on,
  output logic               overrun
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int POS_W = $clog2(TOTAL);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int WIN_W = COORD_W + 4;

  typedef enum logic [1:0] {IDLE, DRAW, REWIND, ALIGN} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [2:0]         rep_q, rep_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [2:0]         sub_q, sub_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [1:0]         scale_q, scale_d;
  logic               pixel_q, pixel_d;
  logic               overrun_q, overrun_d;

  logic [2:0]       rep_max;
  logic [WIN_W-1:0] win_top, win_bot, vpos_ext;
  logic             entry_hit;

  // Window compare is widened so y + (HEIGHT << scale) never wraps.
  assign rep_max   = 3'((4'd1 << scale_q) - 4'd1);
  assign win_top   = WIN_W'(y_q);
  assign win_bot   = win_top + (WIN_W'(HEIGHT) << scale_q);
  assign vpos_ext  = WIN_W'(vpos);
  assign entry_hit = (hpos == x_q) && (vpos_ext >= win_top) && (vpos_ext < win_bot)
                   && (row_q < ROW_W'(HEIGHT));

  assign pixel_on = pixel_q;
  assign overrun  = overrun_q;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    row_d     = row_q;
    rep_d     = rep_q;
    col_d     = col_q;
    sub_d     = sub_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    scale_d   = scale_q;
    pixel_d   = 1'b0;
    overrun_d = overrun_q;
    shiftf    = 1'b0;
    shiftb    = 1'b0;

    if (entry_hit && (state_q == REWIND || state_q == ALIGN)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (entry_hit) begin
          state_d = DRAW;
          col_d   = '0;
          sub_d   = '0;
        end
      end
      DRAW: begin
        pixel_d = sprite_bit;
        if (sub_q == rep_max) begin
          shiftf = 1'b1;
          sub_d  = '0;
          col_d  = col_q + COL_W'(1);
          if (col_q == COL_W'(WIDTH - 1)) begin
            if (rep_q == rep_max) begin
              rep_d   = '0;
              row_d   = row_q + ROW_W'(1);
              state_d = IDLE;
            end else begin
              rep_d   = rep_q + 3'd1;
              cnt_d   = CNT_W'(WIDTH);
              state_d = REWIND;
            end
          end
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      REWIND: begin
        shiftb = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      ALIGN: shiftf = 1'b1;
      default: state_d = IDLE;
    endcase

    if (shiftf)      pos_d = (pos_q == POS_W'(TOTAL - 1)) ? '0 : pos_q + POS_W'(1);
    else if (shiftb) pos_d = (pos_q == '0) ? POS_W'(TOTAL - 1) : pos_q - POS_W'(1);

    if (state_q == ALIGN && pos_d == '0) state_d = IDLE;

    // Alignment decision uses the post-strobe position of this cycle.
    if (frame_start) begin
      x_d     = sprite_x;
      y_d     = sprite_y;
      scale_d = scale;
      row_d   = '0;
      rep_d   = '0;
      state_d = (pos_d != '0) ? ALIGN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      row_q     <= '0;
      rep_q     <= '0;
      col_q     <= '0;
      sub_q     <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      scale_q   <= '0;
      pixel_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      row_q     <= row_d;
      rep_q     <= rep_d;
      col_q     <= col_d;
      sub_q     <= sub_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      scale_q   <= scale_d;
      pixel_q   <= pixel_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
